// File: rtl/buffer_window_nxn.sv
// buffer_window_nxn
// Square WIN_SIZE x WIN_SIZE pixel window that slides over an image one
// row or column at a time. Each shift drops the edge on one side and
// loads buffer_input on the opposite edge. A fill counter tracks how many
// shifts have happened since reset/clear, and window_valid flags a window
// made only of pixels that were shifted in.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset (beats clear and shift)
//   shift_enable    perform one shift this cycle
//   shift_direction 00 up, 01 right, 10 left, 11 down
//   clear           synchronous flush of window and fill count (beats shift)
//   buffer_input    incoming row (up/down) or column (left/right)
//   buffer_output   registered window, [row][col], row 0 top, col 0 left
//   center_pixel    buffer_output[WIN_SIZE/2][WIN_SIZE/2], combinational
//   fill_count      shifts since reset/clear, saturating at WIN_SIZE
//   window_valid    registered, high when fill_count == WIN_SIZE
module buffer_window_nxn #(
    parameter int WIN_SIZE = 7,
    parameter int PIX_W    = 8,
    parameter int CNT_W    = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          shift_enable,
    input  logic [1:0]                                    shift_direction,
    input  logic                                          clear,
    input  logic [0:WIN_SIZE-1][PIX_W-1:0]                buffer_input,
    output logic [0:WIN_SIZE-1][0:WIN_SIZE-1][PIX_W-1:0]  buffer_output,
    output logic [PIX_W-1:0]                              center_pixel,
    output logic [CNT_W-1:0]                              fill_count,
    output logic                                          window_valid
);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam int              MID  = WIN_SIZE / 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIN_SIZE);

    logic [0:WIN_SIZE-1][0:WIN_SIZE-1][PIX_W-1:0] win_next;
    logic [CNT_W-1:0]                             fill_next;

    // Per-cell source selection. Edge cells take the incoming vector
    // instead of a neighbour; resolving that at elaboration keeps every
    // neighbour index in range.
    for (genvar r = 0; r < WIN_SIZE; r++) begin : g_row
        for (genvar c = 0; c < WIN_SIZE; c++) begin : g_col
            logic [PIX_W-1:0] from_right;
            logic [PIX_W-1:0] from_left;
            logic [PIX_W-1:0] from_below;
            logic [PIX_W-1:0] from_above;

            if (c < WIN_SIZE - 1) begin : g_r
                assign from_right = buffer_output[r][c+1];
            end else begin : g_r_edge
                assign from_right = buffer_input[r];
            end

            if (c > 0) begin : g_l
                assign from_left = buffer_output[r][c-1];
            end else begin : g_l_edge
                assign from_left = buffer_input[r];
            end

            if (r < WIN_SIZE - 1) begin : g_d
                assign from_below = buffer_output[r+1][c];
            end else begin : g_d_edge
                assign from_below = buffer_input[c];
            end

            if (r > 0) begin : g_u
                assign from_above = buffer_output[r-1][c];
            end else begin : g_u_edge
                assign from_above = buffer_input[c];
            end

            assign win_next[r][c] =
                (shift_direction == DIR_RIGHT) ? from_right :
                (shift_direction == DIR_LEFT)  ? from_left  :
                (shift_direction == DIR_DOWN)  ? from_below :
                                                 from_above;
        end
    end

    // Direction changes never touch the counter, so a serpentine scan keeps
    // the window valid once it has been filled.
    always_comb begin
        fill_next = fill_count;
        if (fill_count < FULL)
            fill_next = fill_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            buffer_output <= '0;
            fill_count    <= '0;
            window_valid  <= 1'b0;
        end else if (shift_enable) begin
            buffer_output <= win_next;
            fill_count    <= fill_next;
            window_valid  <= (fill_next == FULL);
        end
    end

    assign center_pixel = buffer_output[MID][MID];

endmodule
